// File: rtl/eth_filter_pkg.sv
// Shared definitions for the Ethernet RX frame filter: FSM state encoding,
// accepted ethertypes, broadcast address, header byte offsets and header
// field extraction helpers.
package eth_filter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_PASS  = 3'd2,
      ST_DROP  = 3'd3,
      ST_DRAIN = 3'd4
   } filt_state_t;

   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
   localparam logic [47:0] MAC_BROADCAST  = 48'hFFFF_FFFF_FFFF;

   // Byte offsets within the frame (beat0 holds bytes 0-7, beat1 bytes 8-15)
   localparam int DST_OFS       = 0;
   localparam int DST_LEN       = 6;
   localparam int ETHERTYPE_OFS = 12;
   localparam int BEAT_BYTES    = 8;

   // Packed beat layout used by the output buffer: {tuser, tlast, tkeep, tdata}
   localparam int BEAT_W = 64 + 8 + 1 + 1;

   // Destination MAC from beat0; wire byte 0 lands in bits [47:40]
   function automatic logic [47:0] hdr_dst(input logic [63:0] beat0);
      logic [47:0] mac;
      mac = '0;
      for (int i = 0; i < DST_LEN; i++) begin
         mac[47 - 8*i -: 8] = beat0[8*(DST_OFS + i) +: 8];
      end
      return mac;
   endfunction

   // Ethertype from beat1; the first wire byte is the most significant
   function automatic logic [15:0] hdr_ethertype(input logic [63:0] beat1);
      return {beat1[8*(ETHERTYPE_OFS - BEAT_BYTES) +: 8],
              beat1[8*(ETHERTYPE_OFS - BEAT_BYTES + 1) +: 8]};
   endfunction

endpackage

// File: rtl/eth_axis_skid2.sv
// Two-entry output buffer (output register + hold register) for the frame
// filter. The FSM either loads both entries at once (header decision) or
// pushes single beats; upstream ready is "hold empty or consumer ready",
// so beats stream with no bubbles and nothing changes while stalled.
module eth_axis_skid2
   import eth_filter_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              load2_i,
   input  logic [BEAT_W-1:0] load_out_i,
   input  logic [BEAT_W-1:0] load_hold_i,
   input  logic              push_i,
   input  logic [BEAT_W-1:0] push_beat_i,
   output logic              in_ready_o,
   output logic              m_valid_o,
   output logic [BEAT_W-1:0] m_beat_o,
   input  logic              m_ready_i
);

   logic [BEAT_W-1:0] out_q, out_d;
   logic [BEAT_W-1:0] hold_q, hold_d;
   logic              out_valid_q, out_valid_d;
   logic              hold_valid_q, hold_valid_d;
   logic              pop;

   assign pop        = out_valid_q & m_ready_i;
   assign in_ready_o = ~hold_valid_q | m_ready_i;
   assign m_valid_o  = out_valid_q;
   assign m_beat_o   = out_q;

   // Next-state for both entries: hold always drains into out before new data
   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      if (flush_i) begin
         out_valid_d  = 1'b0;
         hold_valid_d = 1'b0;
      end else if (load2_i) begin
         out_d        = load_out_i;
         hold_d       = load_hold_i;
         out_valid_d  = 1'b1;
         hold_valid_d = 1'b1;
      end else if (hold_valid_q) begin
         if (pop) begin
            out_d = hold_q;
            if (push_i) begin
               hold_d = push_beat_i;
            end else begin
               hold_valid_d = 1'b0;
            end
         end
      end else if (push_i) begin
         if (out_valid_q && !pop) begin
            hold_d       = push_beat_i;
            hold_valid_d = 1'b1;
         end else begin
            out_d       = push_beat_i;
            out_valid_d = 1'b1;
         end
      end else if (pop) begin
         out_valid_d = 1'b0;
      end
   end

   // Buffer registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_q        <= '0;
         hold_q       <= '0;
         out_valid_q  <= 1'b0;
         hold_valid_q <= 1'b0;
      end else begin
         out_q        <= out_d;
         hold_q       <= hold_d;
         out_valid_q  <= out_valid_d;
         hold_valid_q <= hold_valid_d;
      end
   end

endmodule

// File: rtl/eth_rx_frame_filter.sv
// Receive frame filter: inspects the destination MAC (beat0) and ethertype
// (beat1) of each frame and forwards matching unicast/broadcast/multicast
// IPv4 or ARP frames unchanged; everything else is swallowed at full rate.
// Optional statistics counters are built when ETH_RX_FILTER_STATS_EN is
// defined; otherwise pass_count/drop_count are tied to zero.
module eth_rx_frame_filter
   import eth_filter_pkg::*;
#(
   parameter int WIDTH = 64
)
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [47:0]        local_mac,
   input  logic               accept_mcast,
   input  logic [WIDTH-1:0]   s_axis_tdata,
   input  logic [WIDTH/8-1:0] s_axis_tkeep,
   input  logic               s_axis_tvalid,
   input  logic               s_axis_tlast,
   input  logic               s_axis_tuser,
   output logic               s_axis_tready,
   output logic [WIDTH-1:0]   m_axis_tdata,
   output logic [WIDTH/8-1:0] m_axis_tkeep,
   output logic               m_axis_tvalid,
   output logic               m_axis_tlast,
   output logic               m_axis_tuser,
   input  logic               m_axis_tready,
   output logic               frame_drop,
   output logic [31:0]        pass_count,
   output logic [31:0]        drop_count
);

   filt_state_t       state_q;
   logic              run_q;
   logic              frame_drop_q;
   logic [63:0]       hdr_data_q;
   logic [7:0]        hdr_keep_q;
   logic              hdr_user_q;

   logic              s_fire;
   logic              m_last_fire;
   logic [47:0]       dst;
   logic [15:0]       ethertype;
   logic              addr_ok;
   logic              type_ok;
   logic              hdr_pass;
   logic              skid_ready;
   logic              skid_load2;
   logic              skid_push;
   logic              skid_flush;
   logic [BEAT_W-1:0] skid_m_beat;

   assign s_fire      = s_axis_tvalid & s_axis_tready;
   assign m_last_fire = m_axis_tvalid & m_axis_tready & m_axis_tlast;

   // Header decision, evaluated while beat1 is on the input
   assign dst       = hdr_dst(hdr_data_q);
   assign ethertype = hdr_ethertype(s_axis_tdata);
   assign addr_ok   = (dst == local_mac) || (dst == MAC_BROADCAST) ||
                      (accept_mcast && hdr_data_q[0]);
   assign type_ok   = (ethertype == ETHERTYPE_IPV4) || (ethertype == ETHERTYPE_ARP);
   assign hdr_pass  = addr_ok & type_ok;

   // Upstream ready per state; held low until the first clock after reset
   always_comb begin
      s_axis_tready = 1'b0;
      case (state_q)
         ST_IDLE, ST_HDR, ST_DROP: s_axis_tready = run_q;
         ST_PASS:                  s_axis_tready = run_q & skid_ready;
         default:                  s_axis_tready = 1'b0;
      endcase
   end

   assign skid_load2 = (state_q == ST_HDR) && s_fire && hdr_pass;
   assign skid_push  = (state_q == ST_PASS) && s_fire;
   assign skid_flush = (state_q == ST_IDLE);

   eth_axis_skid2 u_skid (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (skid_flush),
      .load2_i     (skid_load2),
      .load_out_i  ({hdr_user_q, 1'b0, hdr_keep_q, hdr_data_q}),
      .load_hold_i ({s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
      .push_i      (skid_push),
      .push_beat_i ({s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
      .in_ready_o  (skid_ready),
      .m_valid_o   (m_axis_tvalid),
      .m_beat_o    (skid_m_beat),
      .m_ready_i   (m_axis_tready)
   );

   assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = skid_m_beat;
   assign frame_drop = frame_drop_q;

   // Frame FSM: header capture, pass/drop decision, drop pulse, drain wait
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         run_q        <= 1'b0;
         frame_drop_q <= 1'b0;
         hdr_data_q   <= '0;
         hdr_keep_q   <= '0;
         hdr_user_q   <= 1'b0;
      end else begin
         run_q        <= 1'b1;
         frame_drop_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (s_fire) begin
                  if (s_axis_tlast) begin
                     frame_drop_q <= 1'b1;
                  end else begin
                     hdr_data_q <= s_axis_tdata;
                     hdr_keep_q <= s_axis_tkeep;
                     hdr_user_q <= s_axis_tuser;
                     state_q    <= ST_HDR;
                  end
               end
            end
            ST_HDR: begin
               if (s_fire) begin
                  if (hdr_pass) begin
                     state_q <= s_axis_tlast ? ST_DRAIN : ST_PASS;
                  end else begin
                     frame_drop_q <= 1'b1;
                     state_q      <= s_axis_tlast ? ST_IDLE : ST_DROP;
                  end
               end
            end
            ST_PASS: begin
               if (s_fire && s_axis_tlast) state_q <= ST_DRAIN;
            end
            ST_DROP: begin
               if (s_fire && s_axis_tlast) state_q <= ST_IDLE;
            end
            ST_DRAIN: begin
               if (m_last_fire) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef ETH_RX_FILTER_STATS_EN
   logic [31:0] pass_count_q;
   logic [31:0] drop_count_q;

   // Frame statistics, wrapping modulo 2^32
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pass_count_q <= '0;
         drop_count_q <= '0;
      end else begin
         if (m_last_fire)  pass_count_q <= pass_count_q + 32'd1;
         if (frame_drop_q) drop_count_q <= drop_count_q + 32'd1;
      end
   end

   assign pass_count = pass_count_q;
   assign drop_count = drop_count_q;
`else
   assign pass_count = 32'd0;
   assign drop_count = 32'd0;
`endif

endmodule
